// File: rtl/pwm_wb_pkg.sv
// Shared definitions for the PWM timer Wishbone slice: arbiter states, bus widths, register map.
package pwm_wb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADR_W_DEF  = 16;

  // Register word offsets inside one channel block; channels are CH_STRIDE words apart.
  localparam int REG_CTRL    = 0;
  localparam int REG_PERIOD  = 1;
  localparam int REG_DIVISOR = 2;
  localparam int REG_DC      = 3;
  localparam int CH_STRIDE   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  function automatic logic [ADR_W_DEF-1:0] ch_reg_adr(input int ch, input int off);
    return ADR_W_DEF'(ch * CH_STRIDE + off);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          vld
);

  logic [PW:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    vld = |req;
    // Walk from farthest to nearest so the candidate closest to ptr is written last.
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (req[pos[PW-1:0]]) idx = pos[PW-1:0];
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/pwm_wb_arbiter.sv
// Round-robin arbiter running one classic Wishbone cycle per grant (IDLE -> BUS -> DONE).
// Optional ack timeout with error pulse is enabled by defining PWM_WB_ARB_TIMEOUT_EN.
module pwm_wb_arbiter
  import pwm_wb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADR_W   = ADR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                      i_wb_clk,
  input  logic                      i_wb_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*ADR_W-1:0]  i_req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ack,
  output logic [NUM_REQ-1:0]        o_req_err,
  output logic [DATA_W-1:0]         o_req_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_busy,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [ADR_W-1:0]          o_wb_adr,
  output logic [DATA_W-1:0]         o_wb_data,
  input  logic                      i_wb_ack,
  input  logic [DATA_W-1:0]         i_wb_data
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_t         state, state_nxt;
  logic [PW-1:0]      ptr, owner;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_vld;
  logic               done_ok, done_to;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign done_ok = (state == ST_BUS) && i_wb_ack;

`ifdef PWM_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)          to_cnt <= '0;
    else if (state != ST_BUS) to_cnt <= '0;
    else                      to_cnt <= to_cnt + CW'(1);
  end

  // Expiry on the TIMEOUT-th BUS cycle; a coincident ack takes precedence.
  assign done_to = (state == ST_BUS) && !i_wb_ack && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_req_err <= '0;
    end else begin
      o_req_err <= '0;
      if (done_to) o_req_err[owner] <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign done_to   = 1'b0;
  assign o_req_err = '0;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pick_vld) state_nxt = ST_BUS;
      ST_BUS:  if (done_ok || done_to) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_busy   = 1'b0;
    o_gnt    = '0;
    if (state == ST_BUS) begin
      o_wb_cyc     = 1'b1;
      o_wb_stb     = 1'b1;
      o_busy       = 1'b1;
      o_gnt[owner] = 1'b1;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      ptr        <= '0;
      owner      <= '0;
      o_wb_we    <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_data  <= '0;
      o_req_data <= '0;
      o_req_ack  <= '0;
    end else begin
      o_req_ack <= '0;
      // Payload is captured only here, so requesters may change it once granted.
      if (state == ST_IDLE && pick_vld) begin
        owner     <= pick_idx;
        o_wb_we   <= i_req_we[pick_idx];
        o_wb_adr  <= i_req_adr[pick_idx*ADR_W +: ADR_W];
        o_wb_data <= i_req_data[pick_idx*DATA_W +: DATA_W];
      end
      if (done_ok) begin
        o_req_ack[owner] <= 1'b1;
        if (!o_wb_we) o_req_data <= i_wb_data;
      end
      if (done_ok || done_to) ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
    end
  end

endmodule

// File: doc/pwm_wb_arbiter.md
Name: pwm_wb_arbiter

Overview:
- Round-robin Wishbone bus arbiter/master that shares the PWM timer's single Wishbone slave port between NUM_REQ configuration requesters.
- Example requesters: CPU bridge, DMA engine, per-channel duty-cycle updater.
- Accepts one register read or write per requester handshake and runs it as one classic single Wishbone cycle.
- Returns a one-cycle completion pulse with read data, or an error pulse on timeout.
- Sits directly in front of the PWM timer top-level Wishbone inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, Wishbone data width; matches the PWM register file word width.
- ADR_W, 16, Wishbone address width.
- TIMEOUT, 16, maximum cycles in BUS waiting for ack (only used when the optional feature is enabled).

Ports:
- i_wb_clk  in  1  Wishbone clock; single clock domain.
- i_wb_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_REQ  per-requester transaction request.
- i_req_we  in  NUM_REQ  per-requester write enable (1 = write).
- i_req_adr  in  NUM_REQ*ADR_W  flattened addresses; requester k at [k*ADR_W +: ADR_W].
- i_req_data  in  NUM_REQ*DATA_W  flattened write data.
- o_req_ack  out  NUM_REQ  one-cycle completion pulse for the owning requester.
- o_req_err  out  NUM_REQ  one-cycle timeout pulse for the owning requester.
- o_req_data  out  DATA_W  read data; valid with o_req_ack.
- o_gnt  out  NUM_REQ  one-hot current owner; zero when idle.
- o_busy  out  1  high while in BUS.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_adr  out  ADR_W  Wishbone address.
- o_wb_data  out  DATA_W  Wishbone write data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_data  in  DATA_W  slave read data.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, round-robin pointer = 0.
- Reset mid-cycle: cyc/stb drop immediately; no ack or err pulse is issued.
- States: IDLE, BUS, DONE.
- IDLE:
  - If any i_req is high, select the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - Register its we/adr/data into o_wb_*, set o_gnt, and assert o_wb_cyc = o_wb_stb = 1 on the next edge.
  - Latency: request sampled in cycle 0, stb high in cycle 1.
- BUS:
  - cyc, stb, we, adr and data stay constant until termination.
  - On i_wb_ack: capture i_wb_data into o_req_data when we = 0 (o_req_data holds until the next read ack).
  - Drop cyc/stb, pulse o_req_ack[owner] for one cycle, set pointer = owner+1 mod NUM_REQ, and go to DONE.
- DONE:
  - One dead cycle; o_gnt cleared, then IDLE.
  - Guarantees cyc deasserts between transactions, so back-to-back transactions take at least 3 cycles plus slave latency.
- Requester rules:
  - Hold i_req and payload until ack or err. Payload is sampled only at grant.
  - Deasserting i_req while granted does not abort the bus cycle; the completion pulse is still issued.
  - A requester still high after its ack is treated as a new request, at lowest priority.
- i_wb_ack outside BUS is ignored.
- Address and data pass through unmodified; no decoding.
- With all NUM_REQ requesting continuously, service order is 0,1,2,3,0,... and there is no starvation.

Optional Feature:
- Macro: PWM_WB_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on entering BUS and increments every cycle in BUS.
  - If it reaches TIMEOUT with no ack: drop cyc/stb, pulse o_req_err[owner], leave o_req_data unchanged, advance the pointer, go to DONE.
  - An ack in the same cycle as expiry wins: ack pulse, no err.
- Not defined: no counter; BUS waits indefinitely; o_req_err is tied to 0.

Decomposition:
- Shared package pwm_wb_pkg:
  - State encoding enum (IDLE, BUS, DONE).
  - Default DATA_W/ADR_W constants, shared with the PWM register file.
  - Register offset constants (CTRL = 0, PERIOD = 1, DIVISOR = 2, DC = 3, stride 4 per channel) for requesters and benches.
- Sub-module rr_picker: combinational round-robin select.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, binary index, any-valid flag.
- The FSM, payload registers and timeout counter stay in pwm_wb_arbiter.

Test Plan:
- Single write: req1, adr 0x0005, data 0x00FF, slave acks 2 cycles after stb. Expect:
  - stb in cycle 1 with o_wb_adr = 0x0005, o_wb_data = 0x00FF, o_wb_we = 1.
  - o_req_ack = 0010 pulse for one cycle.
  - Pointer = 2.
- Read: req0 reads adr 0x0003, slave returns 0x1234. Expect o_req_data = 0x1234 coincident with o_req_ack = 0001, and held afterwards.
- Fairness: all four requesting continuously for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3 and cyc low for one cycle between each.
- Timeout (macro on, TIMEOUT = 16, slave never acks): expect o_req_err pulse exactly 16 cycles after stb rises, no ack, then the next requester is served.
- Ack at expiry: ack arrives on cycle 16. Expect o_req_ack only, and o_req_err stays 0.
- Async reset mid-BUS: assert i_wb_rst_n low. Expect o_wb_cyc, o_wb_stb and o_gnt to go 0 immediately, no pulses, and pointer 0 after release.
